// File: rtl/slab_interval_seq.sv
// Ray/AABB slab combiner: reduces six per-axis entry/exit distances via an external FP less-than unit.
// Latency: out_valid rises 6*(CMP_LAT+1)+1 cycles after the accept edge.
// Backpressure: in_ready only in IDLE; result held with out_valid until out_ready, no new job until then.
module slab_interval_seq #(
    parameter int width   = 16,
    parameter int CMP_LAT = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [width:0]   tnear_x,
    input  logic [width:0]   tnear_y,
    input  logic [width:0]   tnear_z,
    input  logic [width:0]   tfar_x,
    input  logic [width:0]   tfar_y,
    input  logic [width:0]   tfar_z,
    output logic [width:0]   cmp_a,
    output logic [width:0]   cmp_b,
    input  logic             cmp_less,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_hit,
    output logic [width:0]   out_tmin,
    output logic [width:0]   out_tmax
);

    // Wait counter runs 0..CMP_LAT-1; CMP_LAT=1 still needs a one-bit counter.
    localparam int CW = (CMP_LAT > 1) ? $clog2(CMP_LAT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CMP_LAT - 1);

    // Comparison steps, in issue order.
    localparam logic [2:0] STEP_NEAR_XY  = 3'd0;
    localparam logic [2:0] STEP_NEAR_Z   = 3'd1;
    localparam logic [2:0] STEP_FAR_XY   = 3'd2;
    localparam logic [2:0] STEP_FAR_Z    = 3'd3;
    localparam logic [2:0] STEP_OVERLAP  = 3'd4;
    localparam logic [2:0] STEP_BEHIND   = 3'd5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    // Latched job operands.
    logic [width:0] nx, ny, nz;
    logic [width:0] fx, fy, fz;

    // Running reductions and the two final comparison flags.
    logic [width:0] tmin;
    logic [width:0] tmax;
    logic           lt;
    logic           neg;

    logic [2:0]     step;
    logic [CW-1:0]  cnt;
    logic           last_wait;
    logic           accept;

    logic [width:0] pair_a;
    logic [width:0] pair_b;

    assign last_wait = (cnt == CNT_LAST);
    assign accept    = (state == IDLE) && in_valid;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and the ready handshake toward the requester.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                state_nxt = WAIT;
            end
            WAIT: begin
                if (last_wait) begin
                    state_nxt = (step == STEP_BEHIND) ? DONE : ISSUE;
                end
            end
            DONE: begin
                // The first DONE cycle publishes the result; release needs it visible.
                if (out_valid && out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Operand pair for the current step; later steps consume the running tmin/tmax.
    always_comb begin
        pair_a = '0;
        pair_b = '0;
        case (step)
            STEP_NEAR_XY: begin
                pair_a = nx;
                pair_b = ny;
            end
            STEP_NEAR_Z: begin
                pair_a = tmin;
                pair_b = nz;
            end
            STEP_FAR_XY: begin
                pair_a = fy;
                pair_b = fx;
            end
            STEP_FAR_Z: begin
                pair_a = fz;
                pair_b = tmax;
            end
            STEP_OVERLAP: begin
                pair_a = tmin;
                pair_b = tmax;
            end
            STEP_BEHIND: begin
                // Compare against +0 (exc 00) to detect a box entirely behind the ray.
                pair_a = tmax;
                pair_b = '0;
            end
            default: begin
                pair_a = '0;
                pair_b = '0;
            end
        endcase
    end

    // Input latch, comparator issue, result sampling and output publication.
    always_ff @(posedge clk) begin
        if (rst) begin
            nx        <= '0;
            ny        <= '0;
            nz        <= '0;
            fx        <= '0;
            fy        <= '0;
            fz        <= '0;
            tmin      <= '0;
            tmax      <= '0;
            lt        <= 1'b0;
            neg       <= 1'b0;
            step      <= '0;
            cnt       <= '0;
            cmp_a     <= '0;
            cmp_b     <= '0;
            out_valid <= 1'b0;
            out_hit   <= 1'b0;
            out_tmin  <= '0;
            out_tmax  <= '0;
        end else begin
            if (accept) begin
                nx   <= tnear_x;
                ny   <= tnear_y;
                nz   <= tnear_z;
                fx   <= tfar_x;
                fy   <= tfar_y;
                fz   <= tfar_z;
                step <= STEP_NEAR_XY;
            end

            if (state == ISSUE) begin
                cmp_a <= pair_a;
                cmp_b <= pair_b;
                cnt   <= '0;
            end

            if (state == WAIT) begin
                if (!last_wait) begin
                    cnt <= cnt + CW'(1);
                end else begin
                    // cmp_less is only trusted on the CMP_LAT-th edge after the pair appeared.
                    case (step)
                        STEP_NEAR_XY: tmin <= cmp_less ? ny : nx;
                        STEP_NEAR_Z:  tmin <= cmp_less ? nz : tmin;
                        STEP_FAR_XY:  tmax <= cmp_less ? fy : fx;
                        STEP_FAR_Z:   tmax <= cmp_less ? fz : tmax;
                        STEP_OVERLAP: lt   <= cmp_less;
                        STEP_BEHIND:  neg  <= cmp_less;
                        default:      lt   <= lt;
                    endcase
                    if (step != STEP_BEHIND) begin
                        step <= step + 3'd1;
                    end
                end
            end

            if (state == DONE) begin
                if (!out_valid) begin
                    out_valid <= 1'b1;
                    out_hit   <= lt & ~neg;
                    out_tmin  <= tmin;
                    out_tmax  <= tmax;
                end else if (out_ready) begin
                    // Result fields stay as they are after the handshake.
                    out_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_slab_interval_seq.sv
// Directed and randomized jobs for the slab combiner against a value-level reference model.
// Comparator model: true FP less, valid only once a pair has been stable CMP_LAT cycles.
// Output handshake exercised with and without held-off out_ready.
module tb_slab_interval_seq;

    localparam int W   = 16;
    localparam int LAT = 3;

    localparam logic [W:0] F_0P5 = 17'h09000;
    localparam logic [W:0] F_1P0 = 17'h09800;
    localparam logic [W:0] F_2P0 = 17'h0A000;
    localparam logic [W:0] F_3P0 = 17'h0A400;
    localparam logic [W:0] F_M1  = 17'h0D800;
    localparam logic [W:0] F_M2  = 17'h0E000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W:0]   tnear_x, tnear_y, tnear_z;
    logic [W:0]   tfar_x, tfar_y, tfar_z;
    logic [W:0]   cmp_a, cmp_b;
    logic         cmp_less;
    logic         out_valid;
    logic         out_ready;
    logic         out_hit;
    logic [W:0]   out_tmin, out_tmax;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference results for the job in flight.
    logic [W:0] exp_tmin, exp_tmax;
    logic       exp_hit;
    logic [W:0] exp_pa [6];
    logic [W:0] exp_pb [6];

    // Values the DUT published for the last job.
    logic [W:0] got_tmin, got_tmax;
    logic       got_hit;

    slab_interval_seq #(.width(W), .CMP_LAT(LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .tnear_x   (tnear_x),
        .tnear_y   (tnear_y),
        .tnear_z   (tnear_z),
        .tfar_x    (tfar_x),
        .tfar_y    (tfar_y),
        .tfar_z    (tfar_z),
        .cmp_a     (cmp_a),
        .cmp_b     (cmp_b),
        .cmp_less  (cmp_less),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_hit   (out_hit),
        .out_tmin  (out_tmin),
        .out_tmax  (out_tmax)
    );

    // Signed ordering key of a finite value: zero (either sign) is 0, normals by {exp,frac}.
    function automatic int fp_key(input logic [W:0] a);
        int mag;
        if (a[W-1] == 1'b0) return 0;
        mag = int'(a[W-3:0]) + 1;
        return a[W-2] ? -mag : mag;
    endfunction

    // Real-valued less-than; equal, inf or NaN operands give 0.
    function automatic logic fp_less(input logic [W:0] a, input logic [W:0] b);
        if ($isunknown({a, b})) return 1'bx;
        if (a[W] || b[W]) return 1'b0;
        return fp_key(a) < fp_key(b);
    endfunction

    // Comparator: result reflects the current pair only once it has been held LAT cycles.
    logic [2*W+1:0] hist [LAT];
    always @(negedge clk) begin
        logic stable;
        for (int i = LAT - 1; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = {cmp_a, cmp_b};
        stable = 1'b1;
        for (int i = 1; i < LAT; i++) if (hist[i] !== hist[0]) stable = 1'b0;
        cmp_less = stable ? fp_less(cmp_a, cmp_b) : 1'bx;
    end

    task automatic chk(input string tag, input logic [W:0] obs, input logic [W:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // tmin = largest entry, tmax = smallest exit, earliest operand kept on ties;
    // hit when the interval is non-empty and does not lie entirely behind the origin.
    task automatic model(input logic [W:0] nx, ny, nz, fx, fy, fz);
        logic [W:0] m1, m2, x1, x2;
        m1 = fp_less(nx, ny) ? ny : nx;
        m2 = fp_less(m1, nz) ? nz : m1;
        x1 = fp_less(fy, fx) ? fy : fx;
        x2 = fp_less(fz, x1) ? fz : x1;
        exp_tmin = m2;
        exp_tmax = x2;
        exp_hit  = fp_less(m2, x2) && !fp_less(x2, '0);
        exp_pa[0] = nx; exp_pb[0] = ny;
        exp_pa[1] = m1; exp_pb[1] = nz;
        exp_pa[2] = fy; exp_pb[2] = fx;
        exp_pa[3] = fz; exp_pb[3] = x1;
        exp_pa[4] = m2; exp_pb[4] = x2;
        exp_pa[5] = x2; exp_pb[5] = '0;
    endtask

    function automatic logic [W:0] rand_fp();
        logic [W:0] pool [4];
        pool[0] = F_1P0; pool[1] = F_2P0; pool[2] = F_M1; pool[3] = F_0P5;
        case ($urandom_range(0, 7))
            0:       return {2'b00, 1'($urandom_range(0, 1)), 14'h0};
            1, 2:    return pool[$urandom_range(0, 3)];
            3:       return {2'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 13'($urandom)};
            default: return {2'b01, 1'($urandom_range(0, 1)), 14'($urandom)};
        endcase
    endfunction

    // Starts and ends just after a falling edge. Drives garbage on the job inputs while busy
    // when noisy is set, and holds out_ready low for hold cycles once the result is up.
    task automatic run_job(input logic [W:0] nx, ny, nz, fx, fy, fz,
                           input int hold, input bit noisy);
        model(nx, ny, nz, fx, fy, fz);
        tnear_x = nx; tnear_y = ny; tnear_z = nz;
        tfar_x  = fx; tfar_y  = fy; tfar_z  = fz;
        in_valid = 1'b1;
        chk("in_ready_idle", in_ready, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("in_ready_busy", in_ready, 1'b0);
        for (int e = 1; e <= 25; e++) begin
            if (noisy) begin
                in_valid = 1'($urandom_range(0, 1));
                tnear_x = rand_fp(); tnear_y = rand_fp(); tnear_z = rand_fp();
                tfar_x  = rand_fp(); tfar_y  = rand_fp(); tfar_z  = rand_fp();
            end
            @(negedge clk);
            if (e % 4 == 3) begin
                chk($sformatf("pair_a_step%0d", e / 4 + 1), cmp_a, exp_pa[e/4]);
                chk($sformatf("pair_b_step%0d", e / 4 + 1), cmp_b, exp_pb[e/4]);
            end
            if (e == 24) chk("valid_not_early", out_valid, 1'b0);
        end
        chk("valid_at_25", out_valid, 1'b1);
        chk("tmin", out_tmin, exp_tmin);
        chk("tmax", out_tmax, exp_tmax);
        chk("hit", out_hit, exp_hit);
        got_tmin = out_tmin; got_tmax = out_tmax; got_hit = out_hit;
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            tnear_x = rand_fp(); tfar_x = rand_fp();
            @(negedge clk);
            chk("bp_valid", out_valid, 1'b1);
            chk("bp_in_ready", in_ready, 1'b0);
            chk("bp_tmin", out_tmin, exp_tmin);
            chk("bp_tmax", out_tmax, exp_tmax);
            chk("bp_hit", out_hit, exp_hit);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("valid_drop", out_valid, 1'b0);
        chk("ready_back", in_ready, 1'b1);
        chk("tmin_kept", out_tmin, exp_tmin);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        tnear_x = '0; tnear_y = '0; tnear_z = '0;
        tfar_x  = '0; tfar_y  = '0; tfar_z  = '0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_hit", out_hit, 1'b0);
        chk("rst_tmin", out_tmin, '0);
        chk("rst_tmax", out_tmax, '0);
        chk("rst_cmp_a", cmp_a, '0);
        chk("rst_cmp_b", cmp_b, '0);
        rst = 1'b0;
        @(negedge clk);

        // Hit.
        run_job(F_0P5, F_1P0, F_M1, F_2P0, F_3P0, F_2P0, 0, 1'b0);
        chk("s1_tmin", got_tmin, 17'h09800);
        chk("s1_tmax", got_tmax, 17'h0A000);
        chk("s1_hit", got_hit, 1'b1);

        // Disjoint slabs.
        run_job(F_2P0, F_0P5, F_0P5, F_3P0, F_1P0, F_3P0, 0, 1'b0);
        chk("s2_tmin", got_tmin, 17'h0A000);
        chk("s2_tmax", got_tmax, 17'h09800);
        chk("s2_hit", got_hit, 1'b0);

        // Box behind the ray.
        run_job(F_M2, F_M2, F_M2, F_M1, F_M1, F_M1, 0, 1'b0);
        chk("s3_tmin", got_tmin, 17'h0E000);
        chk("s3_tmax", got_tmax, 17'h0D800);
        chk("s3_hit", got_hit, 1'b0);

        // All ties: degenerate interval is a miss.
        run_job(F_1P0, F_1P0, F_1P0, F_1P0, F_1P0, F_1P0, 0, 1'b0);
        chk("s4_tmin", got_tmin, 17'h09800);
        chk("s4_tmax", got_tmax, 17'h09800);
        chk("s4_hit", got_hit, 1'b0);

        // Result held off for 10 cycles, then a follow-on job.
        run_job(F_0P5, F_1P0, F_M1, F_2P0, F_3P0, F_2P0, 10, 1'b1);
        run_job(F_2P0, F_0P5, F_0P5, F_3P0, F_1P0, F_3P0, 0, 1'b0);
        chk("s5_next_tmin", got_tmin, 17'h0A000);

        // Reset while step 3 is waiting on the comparator.
        tnear_x = F_0P5; tnear_y = F_1P0; tnear_z = F_M1;
        tfar_x  = F_2P0; tfar_y  = F_3P0; tfar_z  = F_2P0;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("s6_in_ready", in_ready, 1'b1);
        chk("s6_out_valid", out_valid, 1'b0);
        chk("s6_cmp_a", cmp_a, '0);
        chk("s6_cmp_b", cmp_b, '0);
        run_job(F_0P5, F_1P0, F_M1, F_2P0, F_3P0, F_2P0, 0, 1'b0);
        chk("s6_tmin", got_tmin, 17'h09800);
        chk("s6_hit", got_hit, 1'b1);

        // Randomized jobs with random hold-off and busy-time input noise.
        for (int j = 0; j < 40; j++) begin
            logic [W:0] r0, r1, r2, r3, r4, r5;
            r0 = rand_fp(); r1 = rand_fp(); r2 = rand_fp();
            r3 = rand_fp(); r4 = rand_fp(); r5 = rand_fp();
            run_job(r0, r1, r2, r3, r4, r5, $urandom_range(0, 3), 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
